// File: rtl/modsub_arbiter.sv
// modsub_arbiter: round-robin sequencer sharing one (A - B) mod P unit among NUM_REQ requesters
module modsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_p_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     sub_start_o,
  output logic [WIDTH-1:0]         sub_a_o,
  output logic [WIDTH-1:0]         sub_b_o,
  output logic [WIDTH-1:0]         sub_p_o,
  input  logic                     sub_finish_i,
  input  logic [WIDTH-1:0]         sub_result_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e        state_q;
  logic [IW-1:0] last_q, gnt_q, gnt_d, idx;
  logic [CW-1:0] cnt_q;
  logic          any;
  // search upward from last_grant+1 with wrap; lowest offset wins
  always_comb begin
    gnt_d = last_q;
    any = 1'b0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(last_q) + i) % NUM_REQ);
      if (req_valid_i[idx]) begin
        gnt_d = idx;
        any = 1'b1;
      end
    end
  end
  assign req_ready_o = (state_q == IDLE && any) ? NUM_REQ'(1) << gnt_d : '0;
  // sequencer: accept, pulse start, wait for finish or timeout, hold response until taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_q      <= IW'(NUM_REQ - 1);
      gnt_q       <= '0;
      cnt_q       <= '0;
      sub_start_o <= 1'b0;
      sub_a_o     <= '0;
      sub_b_o     <= '0;
      sub_p_o     <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      sub_start_o <= 1'b0;
      case (state_q)
        IDLE: if (any) begin
          gnt_q       <= gnt_d;
          sub_a_o     <= req_a_i[gnt_d*WIDTH +: WIDTH];
          sub_b_o     <= req_b_i[gnt_d*WIDTH +: WIDTH];
          sub_p_o     <= req_p_i[gnt_d*WIDTH +: WIDTH];
          sub_start_o <= 1'b1;
          state_q     <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: if (sub_finish_i || cnt_q == CW'(TIMEOUT - 2)) begin
          rsp_valid_o <= NUM_REQ'(1) << gnt_q;
          rsp_data_o  <= sub_finish_i ? sub_result_i : '0;
          rsp_err_o   <= !sub_finish_i;
          state_q     <= RESP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        RESP: if (rsp_ready_i[gnt_q]) begin
          rsp_valid_o <= '0;
          last_q      <= gnt_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modsub_arbiter.sv
// tb_modsub_arbiter: directed checks of arbitration, sequencing, back-pressure, timeout and reset
module tb_modsub_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  localparam int T = 16;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0] req_valid_i = '0;
  logic [N-1:0] rsp_ready_i = '1;
  logic [N-1:0] req_ready_o, rsp_valid_o;
  logic [N*W-1:0] req_a_i = '0, req_b_i = '0, req_p_i = '0;
  logic [W-1:0] rsp_data_o, sub_a_o, sub_b_o, sub_p_o, sub_result_i;
  logic rsp_err_o, sub_start_o, sub_finish_i;
  logic stray = 1'b0;
  logic [W-1:0] r_m = '0;
  int checks = 0, failures = 0, lat = 1, cnt_m = 0;

  modsub_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_p_i(req_p_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .sub_start_o(sub_start_o), .sub_a_o(sub_a_o), .sub_b_o(sub_b_o), .sub_p_o(sub_p_o),
    .sub_finish_i(sub_finish_i), .sub_result_i(sub_result_i)
  );

  always #5 clk_i = ~clk_i;

  // unit model: finishes lat cycles after start (lat=0 never finishes)
  always @(posedge clk_i) begin
    if (sub_start_o) begin
      cnt_m <= lat;
      r_m <= (sub_a_o >= sub_b_o) ? sub_a_o - sub_b_o : sub_a_o - sub_b_o + sub_p_o;
    end else if (cnt_m > 0) cnt_m <= cnt_m - 1;
  end
  assign sub_finish_i = (cnt_m == 1) || stray;
  assign sub_result_i = r_m;

  task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p);
    req_a_i[k*W +: W] = a;
    req_b_i[k*W +: W] = b;
    req_p_i[k*W +: W] = p;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    #1;
    checks++; if ({req_ready_o, rsp_valid_o, rsp_err_o, sub_start_o} !== '0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {req_ready_o, rsp_valid_o, rsp_err_o, sub_start_o}); end
    checks++; if ((rsp_data_o | sub_a_o | sub_b_o | sub_p_o) !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", rsp_data_o | sub_a_o | sub_b_o | sub_p_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk_i);
    set_op(0, 10, 3, 17);
    req_valid_i = 4'b0001;
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready_o); end
    checks++; if (sub_start_o !== 1'b0) begin failures++; $display("FAIL single_start_c0 got=%b exp=0", sub_start_o); end
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    checks++; if (sub_start_o !== 1'b1 || req_ready_o !== 4'b0000) begin failures++; $display("FAIL single_start_c1 got=%b/%b exp=1/0000", sub_start_o, req_ready_o); end
    checks++; if (sub_a_o !== 64'd10 || sub_b_o !== 64'd3 || sub_p_o !== 64'd17) begin failures++; $display("FAIL single_ops got=%0d,%0d,%0d exp=10,3,17", sub_a_o, sub_b_o, sub_p_o); end
    @(negedge clk_i);
    #1;
    checks++; if (sub_start_o !== 1'b0 || rsp_valid_o !== 4'b0000) begin failures++; $display("FAIL single_c2 got=%b/%b exp=0/0000", sub_start_o, rsp_valid_o); end
    @(negedge clk_i);
    #1;
    checks++; if (rsp_valid_o !== 4'b0001 || rsp_data_o !== 64'd7 || rsp_err_o !== 1'b0) begin failures++; $display("FAIL single_rsp got=%b/%0d/%b exp=0001/7/0", rsp_valid_o, rsp_data_o, rsp_err_o); end
    @(negedge clk_i);
    #1;
    checks++; if (rsp_valid_o !== 4'b0000) begin failures++; $display("FAIL single_rsp_clear got=%b exp=0000", rsp_valid_o); end
  endtask

  task automatic test_wrap();
    @(negedge clk_i);
    set_op(2, 3, 10, 17);
    req_valid_i = 4'b0100;
    #1;
    checks++; if (req_ready_o !== 4'b0100) begin failures++; $display("FAIL wrap_ready got=%b exp=0100", req_ready_o); end
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checks++; if (rsp_valid_o !== 4'b0100 || rsp_data_o !== 64'd10 || rsp_err_o !== 1'b0) begin failures++; $display("FAIL wrap_rsp got=%b/%0d/%b exp=0100/10/0", rsp_valid_o, rsp_data_o, rsp_err_o); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_d [N] = '{64'd50, 64'd59, 64'd68, 64'd77};
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < N; k++) set_op(k, 50 + 10 * k, k, 97);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk_i);
      if (n == 0) req_valid_i = '1;
      #1;
      checks++; if (req_ready_o !== 4'(1 << (n % N))) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", n, req_ready_o, 4'(1 << (n % N))); end
      @(negedge clk_i);
      if (n == 4) req_valid_i = '0;
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      checks++; if (rsp_valid_o !== 4'(1 << (n % N)) || rsp_data_o !== exp_d[n % N]) begin failures++; $display("FAIL rr_rsp%0d got=%b/%0d exp=%b/%0d", n, rsp_valid_o, rsp_data_o, 4'(1 << (n % N)), exp_d[n % N]); end
    end
  endtask

  task automatic test_back_pressure();
    @(negedge clk_i);
    set_op(1, 30, 40, 50);
    set_op(3, 12, 8, 13);
    rsp_ready_i = 4'b1101;
    req_valid_i = 4'b1010;
    #1;
    checks++; if (req_ready_o !== 4'b0010) begin failures++; $display("FAIL bp_grant1 got=%b exp=0010", req_ready_o); end
    @(negedge clk_i);
    req_valid_i = 4'b1000;
    @(negedge clk_i);
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk_i);
      #1;
      checks++; if (rsp_valid_o !== 4'b0010 || rsp_data_o !== 64'd40 || req_ready_o !== 4'b0000) begin failures++; $display("FAIL bp_hold_c%0d got=%b/%0d/%b exp=0010/40/0000", c, rsp_valid_o, rsp_data_o, req_ready_o); end
    end
    rsp_ready_i = '1;
    @(negedge clk_i);
    #1;
    checks++; if (rsp_valid_o !== 4'b0000 || req_ready_o !== 4'b1000) begin failures++; $display("FAIL bp_grant3 got=%b/%b exp=0000/1000", rsp_valid_o, req_ready_o); end
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checks++; if (rsp_valid_o !== 4'b1000 || rsp_data_o !== 64'd4) begin failures++; $display("FAIL bp_rsp3 got=%b/%0d exp=1000/4", rsp_valid_o, rsp_data_o); end
  endtask

  task automatic test_timeout(input int l, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p, input logic [W-1:0] exp_d, input logic exp_e);
    lat = l;
    @(negedge clk_i);
    set_op(0, a, b, p);
    req_valid_i = 4'b0001;
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("FAIL to%0d_ready got=%b exp=0001", l, req_ready_o); end
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    checks++; if (sub_start_o !== 1'b1) begin failures++; $display("FAIL to%0d_issue got=%b exp=1", l, sub_start_o); end
    for (int c = 2; c <= T; c++) begin
      @(negedge clk_i);
      #1;
      checks++; if (rsp_valid_o !== 4'b0000 || sub_start_o !== 1'b0) begin failures++; $display("FAIL to%0d_early_c%0d got=%b/%b exp=0000/0", l, c, rsp_valid_o, sub_start_o); end
    end
    @(negedge clk_i);
    #1;
    checks++; if (rsp_valid_o !== 4'b0001 || rsp_data_o !== exp_d || rsp_err_o !== exp_e) begin failures++; $display("FAIL to%0d_rsp got=%b/%0d/%b exp=0001/%0d/%b", l, rsp_valid_o, rsp_data_o, rsp_err_o, exp_d, exp_e); end
  endtask

  task automatic test_reset_wait();
    lat = 0;
    @(negedge clk_i);
    set_op(2, 7, 1, 11);
    req_valid_i = 4'b0100;
    #1;
    checks++; if (req_ready_o !== 4'b0100) begin failures++; $display("FAIL rw_grant got=%b exp=0100", req_ready_o); end
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checks++; if ({req_ready_o, rsp_valid_o, rsp_err_o, sub_start_o} !== '0 || (rsp_data_o | sub_a_o | sub_b_o | sub_p_o) !== '0) begin failures++; $display("FAIL rw_reset got=%b/%h exp=0/0", {req_ready_o, rsp_valid_o, rsp_err_o, sub_start_o}, rsp_data_o | sub_a_o | sub_b_o | sub_p_o); end
    @(negedge clk_i);
    stray = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    stray = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      #1;
      checks++; if (rsp_valid_o !== 4'b0000 || sub_start_o !== 1'b0) begin failures++; $display("FAIL rw_stray%0d got=%b/%b exp=0000/0", c, rsp_valid_o, sub_start_o); end
    end
    lat = 1;
    @(negedge clk_i);
    set_op(0, 40, 1, 41);
    req_valid_i = '1;
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("FAIL rw_post_grant got=%b exp=0001", req_ready_o); end
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checks++; if (rsp_valid_o !== 4'b0001 || rsp_data_o !== 64'd39 || rsp_err_o !== 1'b0) begin failures++; $display("FAIL rw_post_rsp got=%b/%0d/%b exp=0001/39/0", rsp_valid_o, rsp_data_o, rsp_err_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_back_pressure();
    test_timeout(0, 99, 1, 200, 64'd0, 1'b1);
    test_timeout(T - 1, 20, 5, 23, 64'd15, 1'b0);
    test_reset_wait();
    @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
